div_iter: RTL and testbench

Parametrised iterative integer divider for the execute stage. It computes quotient and remainder for signed or unsigned operands of `WIDTH` bits, retiring `STEP` quotient bits per cycle. A valid/ready handshake on both sides lets the pipeline stall on a busy divider or a blocked writeback. Operands in flight can be cancelled on flush. Division by zero and signed overflow have defined results.

---
 rtl/div_pkg.sv | 19 +
 rtl/div_step.sv | 22 ++
 rtl/div_iter.sv | 142 ++++++++++++++
 tb/tb_div_iter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and elaboration helpers for the iterative divider.
package div_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } div_state_e;

  function automatic bit step_legal(int unsigned step);
    return (step == 1) || (step == 2);
  endfunction

  // Wide enough to hold WIDTH/STEP itself, not just WIDTH/STEP-1.
  function automatic int unsigned cnt_width(int unsigned width, int unsigned step);
    return $clog2(width / step + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] y_abs,
  input  logic             x_bit,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] diff;
  logic             borrow;

  always_comb begin
    diff    = {rem_in, x_bit} - {2'b00, y_abs};
    borrow  = diff[WIDTH+1];
    q_bit   = ~borrow;
    rem_out = borrow ? {rem_in[WIDTH-1:0], x_bit} : diff[WIDTH:0];
  end

endmodule

// File: rtl/div_iter.sv
// Iterative signed/unsigned divider retiring STEP quotient bits per cycle,
// with valid/ready handshakes, flush cancel and defined divide-by-zero results.
module div_iter
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1
) (
  input  logic             div_clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic             cancel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic [WIDTH-1:0] out_r,
  output logic             out_dz
);

  localparam int unsigned     CntW    = cnt_width(WIDTH, STEP);
  localparam logic [CntW-1:0] CntLoad = CntW'(WIDTH / STEP);

  if (!step_legal(STEP) || (WIDTH % STEP) != 0 || WIDTH < 4) begin : g_param_err
    $error("div_iter: illegal WIDTH/STEP combination");
  end

  div_state_e       state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] y_q;
  logic             q_neg_q;
  logic             r_neg_q;

  logic             x_neg;
  logic             y_neg;
  logic [WIDTH-1:0] x_abs;
  logic [WIDTH-1:0] y_abs;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] rem_fin;
  logic [STEP-1:0]  q_bits;
  logic [STEP:0][WIDTH:0] rem_chain;

  assign in_ready = (state_q == StIdle);

  always_comb begin
    x_neg   = in_signed & in_x[WIDTH-1];
    y_neg   = in_signed & in_y[WIDTH-1];
    x_abs   = x_neg ? -in_x : in_x;
    y_abs   = y_neg ? -in_y : in_y;
    q_next  = (q_q << STEP) | WIDTH'(q_bits);
    rem_fin = rem_chain[STEP][WIDTH-1:0];
  end

  assign rem_chain[0] = rem_q;

  // First step in the chain consumes the more significant dividend/quotient bit.
  for (genvar k = 0; k < STEP; k++) begin : g_step
    div_step #(
      .WIDTH (WIDTH)
    ) u_step (
      .rem_in  (rem_chain[k]),
      .y_abs   (y_q),
      .x_bit   (x_q[WIDTH-1-k]),
      .rem_out (rem_chain[k+1]),
      .q_bit   (q_bits[STEP-1-k])
    );
  end

  always_ff @(posedge div_clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      x_q       <= '0;
      q_q       <= '0;
      rem_q     <= '0;
      y_q       <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      out_valid <= 1'b0;
      out_s     <= '0;
      out_r     <= '0;
      out_dz    <= 1'b0;
    end else if (cancel) begin
      state_q   <= StIdle;
      out_valid <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            q_neg_q <= x_neg ^ y_neg;
            r_neg_q <= x_neg;
            y_q     <= y_abs;
            cnt_q   <= CntLoad;
            rem_q   <= '0;
            q_q     <= '0;
            if (in_y == '0) begin
              // Raw dividend is kept so it can be returned as the remainder.
              x_q     <= in_x;
              state_q <= StDone;
            end else begin
              x_q     <= x_abs;
              state_q <= StBusy;
            end
          end
        end
        StBusy: begin
          cnt_q <= cnt_q - CntW'(1);
          x_q   <= x_q << STEP;
          q_q   <= q_next;
          rem_q <= rem_chain[STEP];
          if (cnt_q == CntW'(1)) begin
            out_s     <= q_neg_q ? -q_next : q_next;
            out_r     <= r_neg_q ? -rem_fin : rem_fin;
            out_dz    <= 1'b0;
            out_valid <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          if (!out_valid) begin
            // Divide-by-zero entry: publish the fixed result one edge after accept.
            out_s     <= '1;
            out_r     <= x_q;
            out_dz    <= 1'b1;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: 32/1 directed tests and a 16/2 random sweep.
module tb_div_iter;

  typedef struct packed {
    logic [31:0] s;
    logic [31:0] r;
    logic        dz;
  } res_t;

  logic        div_clk;
  logic        resetn;

  logic        a_in_valid, a_in_ready, a_in_signed, a_cancel;
  logic [31:0] a_in_x, a_in_y, a_out_s, a_out_r;
  logic        a_out_valid, a_out_ready, a_out_dz;

  logic        b_in_valid, b_in_ready, b_in_signed, b_cancel;
  logic [15:0] b_in_x, b_in_y, b_out_s, b_out_r;
  logic        b_out_valid, b_out_ready, b_out_dz;

  res_t sb_a[$];
  res_t sb_b[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  div_iter #(.WIDTH(32), .STEP(1)) u_dut_a (
    .div_clk   (div_clk),
    .resetn    (resetn),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_signed (a_in_signed),
    .in_x      (a_in_x),
    .in_y      (a_in_y),
    .cancel    (a_cancel),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_s     (a_out_s),
    .out_r     (a_out_r),
    .out_dz    (a_out_dz)
  );

  div_iter #(.WIDTH(16), .STEP(2)) u_dut_b (
    .div_clk   (div_clk),
    .resetn    (resetn),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_signed (b_in_signed),
    .in_x      (b_in_x),
    .in_y      (b_in_y),
    .cancel    (b_cancel),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_s     (b_out_s),
    .out_r     (b_out_r),
    .out_dz    (b_out_dz)
  );

  initial div_clk = 1'b0;
  always #5 div_clk = ~div_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Behavioural reference: native integer divide on sign-extended operands.
  function automatic res_t ref_div(input bit sg, input int w, input logic [31:0] x,
                                   input logic [31:0] y);
    res_t   e;
    longint mask;
    longint xl;
    longint yl;
    longint q;
    longint r;
    mask = (longint'(1) << w) - 1;
    xl   = longint'(x) & mask;
    yl   = longint'(y) & mask;
    if (yl == 0) begin
      e.s  = 32'(mask);
      e.r  = 32'(xl);
      e.dz = 1'b1;
      return e;
    end
    if (sg && xl[w-1]) xl = xl - (longint'(1) << w);
    if (sg && yl[w-1]) yl = yl - (longint'(1) << w);
    q    = xl / yl;
    r    = xl % yl;
    e.s  = 32'(q & mask);
    e.r  = 32'(r & mask);
    e.dz = 1'b0;
    return e;
  endfunction

  function automatic logic get_ready(input bit u);
    return u ? b_in_ready : a_in_ready;
  endfunction

  function automatic logic get_valid(input bit u);
    return u ? b_out_valid : a_out_valid;
  endfunction

  function automatic res_t get_out(input bit u);
    res_t o;
    if (u) begin
      o.s = {16'h0, b_out_s}; o.r = {16'h0, b_out_r}; o.dz = b_out_dz;
    end else begin
      o.s = a_out_s; o.r = a_out_r; o.dz = a_out_dz;
    end
    return o;
  endfunction

  task automatic drive_in(input bit u, input bit v, input bit sg, input logic [31:0] x,
                          input logic [31:0] y);
    if (u) begin
      b_in_valid = v; b_in_signed = sg; b_in_x = x[15:0]; b_in_y = y[15:0];
    end else begin
      a_in_valid = v; a_in_signed = sg; a_in_x = x; a_in_y = y;
    end
  endtask

  task automatic set_out_ready(input bit u, input bit v);
    if (u) b_out_ready = v; else a_out_ready = v;
  endtask

  // Called at a negedge; leaves the bench at the negedge after the accept edge.
  task automatic issue_exp(input bit u, input bit sg, input logic [31:0] x,
                           input logic [31:0] y, input res_t e);
    if (u) sb_b.push_back(e); else sb_a.push_back(e);
    check_eq("in_ready_idle", 64'(get_ready(u)), 64'd1);
    drive_in(u, 1'b1, sg, x, y);
    @(posedge div_clk);
    @(negedge div_clk);
    drive_in(u, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic issue(input bit u, input bit sg, input logic [31:0] x, input logic [31:0] y);
    issue_exp(u, sg, x, y, ref_div(sg, u ? 16 : 32, x, y));
  endtask

  task automatic collect(input bit u, input string tag);
    res_t e;
    res_t o;
    int   lat;
    int   exp_lat;
    bit   got;
    lat = 0;
    got = 1'b0;
    if (u ? (sb_b.size() == 0) : (sb_a.size() == 0)) begin
      check_eq({tag, "_sb_empty"}, 64'd1, 64'd0);
      return;
    end
    e       = u ? sb_b.pop_front() : sb_a.pop_front();
    exp_lat = e.dz ? 1 : (u ? 8 : 32);
    while (!got && lat < 100) begin
      @(posedge div_clk);
      lat++;
      @(negedge div_clk);
      got = get_valid(u);
    end
    check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    o = get_out(u);
    check_eq({tag, "_s"}, 64'(o.s), 64'(e.s));
    check_eq({tag, "_r"}, 64'(o.r), 64'(e.r));
    check_eq({tag, "_dz"}, 64'(o.dz), 64'(e.dz));
  endtask

  task automatic ack(input bit u);
    set_out_ready(u, 1'b1);
    @(posedge div_clk);
    @(negedge div_clk);
    set_out_ready(u, 1'b0);
  endtask

  task automatic watch_quiet(input bit u, input string tag);
    bit seen;
    seen = 1'b0;
    repeat (40) begin
      @(negedge div_clk);
      if (get_valid(u)) seen = 1'b1;
    end
    check_eq(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    resetn = 1'b0;
    drive_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive_in(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    a_cancel = 1'b0; b_cancel = 1'b0;
    a_out_ready = 1'b0; b_out_ready = 1'b0;

    #3;
    check_eq("rst_a_flags", 64'({a_out_valid, a_out_dz, a_in_ready}), 64'b001);
    check_eq("rst_a_s", 64'(a_out_s), 64'd0);
    check_eq("rst_a_r", 64'(a_out_r), 64'd0);
    check_eq("rst_b_flags", 64'({b_out_valid, b_out_dz, b_in_ready}), 64'b001);
    repeat (2) @(negedge div_clk);
    resetn = 1'b1;
    @(negedge div_clk);

    // Directed 32/1 vectors.
    issue_exp(0, 0, 32'd100, 32'd7, '{s: 32'd14, r: 32'd2, dz: 1'b0});
    collect(0, "u100_7"); ack(0);
    issue_exp(0, 1, 32'hFFFFFFF9, 32'd2, '{s: 32'hFFFFFFFD, r: 32'hFFFFFFFF, dz: 1'b0});
    collect(0, "sm7_2"); ack(0);
    issue_exp(0, 1, 32'd7, 32'hFFFFFFFE, '{s: 32'hFFFFFFFD, r: 32'd1, dz: 1'b0});
    collect(0, "s7_m2"); ack(0);
    issue_exp(0, 1, 32'hFFFFFFF9, 32'hFFFFFFFE, '{s: 32'd3, r: 32'hFFFFFFFF, dz: 1'b0});
    collect(0, "sm7_m2"); ack(0);
    issue_exp(0, 1, 32'h80000000, 32'hFFFFFFFF, '{s: 32'h80000000, r: 32'd0, dz: 1'b0});
    collect(0, "s_ovf"); ack(0);
    issue_exp(0, 0, 32'hFFFFFFFF, 32'd1, '{s: 32'hFFFFFFFF, r: 32'd0, dz: 1'b0});
    collect(0, "u_max_1"); ack(0);
    issue_exp(0, 0, 32'h1234, 32'd0, '{s: 32'hFFFFFFFF, r: 32'h1234, dz: 1'b1});
    collect(0, "dz_u"); ack(0);
    issue_exp(0, 1, 32'hFFFFFF00, 32'd0, '{s: 32'hFFFFFFFF, r: 32'hFFFFFF00, dz: 1'b1});
    collect(0, "dz_s"); ack(0);

    // Backpressure: hold the result, ignore a pending request, then release.
    issue_exp(0, 0, 32'd1000, 32'd33, '{s: 32'd30, r: 32'd10, dz: 1'b0});
    collect(0, "bp");
    drive_in(0, 1'b1, 1'b0, 32'd5, 32'd3);
    repeat (5) begin
      @(posedge div_clk);
      @(negedge div_clk);
      check_eq("bp_flags", 64'({a_out_valid, a_in_ready, a_out_dz}), 64'b100);
      check_eq("bp_s", 64'(a_out_s), 64'd30);
      check_eq("bp_r", 64'(a_out_r), 64'd10);
    end
    set_out_ready(0, 1'b1);
    @(posedge div_clk);
    @(negedge div_clk);
    set_out_ready(0, 1'b0);
    check_eq("bp_release", 64'({a_out_valid, a_in_ready}), 64'b01);
    sb_a.push_back('{s: 32'd1, r: 32'd2, dz: 1'b0});
    @(posedge div_clk);
    @(negedge div_clk);
    drive_in(0, 1'b0, 1'b0, 32'h0, 32'h0);
    check_eq("bp_accepted", 64'(a_in_ready), 64'd0);
    collect(0, "bp_next"); ack(0);

    // Cancel in the middle of BUSY.
    drive_in(0, 1'b1, 1'b0, 32'd12345, 32'd7);
    @(posedge div_clk);
    @(negedge div_clk);
    drive_in(0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (9) begin
      @(posedge div_clk);
      @(negedge div_clk);
    end
    a_cancel = 1'b1;
    @(posedge div_clk);
    @(negedge div_clk);
    a_cancel = 1'b0;
    check_eq("cancel_busy_idle", 64'({a_out_valid, a_in_ready}), 64'b01);
    watch_quiet(0, "cancel_busy_quiet");
    issue(0, 1, 32'hFFFFFF9C, 32'd9);
    collect(0, "after_cancel"); ack(0);

    // Cancel on the same edge as an IDLE request.
    drive_in(0, 1'b1, 1'b0, 32'd50, 32'd5);
    a_cancel = 1'b1;
    @(posedge div_clk);
    @(negedge div_clk);
    drive_in(0, 1'b0, 1'b0, 32'h0, 32'h0);
    a_cancel = 1'b0;
    check_eq("cancel_idle_ready", 64'(a_in_ready), 64'd1);
    watch_quiet(0, "cancel_idle_quiet");

    // Asynchronous reset mid-BUSY after a nonzero result is registered.
    issue(0, 0, 32'd999, 32'd10);
    collect(0, "pre_reset"); ack(0);
    drive_in(0, 1'b1, 1'b0, 32'd77777, 32'd3);
    @(posedge div_clk);
    @(negedge div_clk);
    drive_in(0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (5) begin
      @(posedge div_clk);
      @(negedge div_clk);
    end
    #2 resetn = 1'b0;
    #1;
    check_eq("rst_busy_flags", 64'({a_out_valid, a_out_dz, a_in_ready}), 64'b001);
    check_eq("rst_busy_s", 64'(a_out_s), 64'd0);
    check_eq("rst_busy_r", 64'(a_out_r), 64'd0);
    @(negedge div_clk);
    resetn = 1'b1;
    @(negedge div_clk);
    issue(0, 1, 32'd123456, 32'hFFFFFFF0);
    collect(0, "post_reset"); ack(0);

    // Random sweep on the 16/2 instance.
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] x;
      logic [31:0] y;
      bit          sg;
      sg = 1'($urandom_range(0, 1));
      x  = {16'h0, 16'($urandom)};
      if ($urandom_range(0, 3) == 0) y = {16'h0, 16'($urandom_range(0, 5))};
      else y = {16'h0, 16'($urandom)};
      if (i == 0) begin x = 32'h8000; y = 32'hFFFF; sg = 1'b1; end
      issue(1, sg, x, y);
      collect(1, "sweep");
      ack(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
